// File: rtl/updown_mod_counter.sv
// Up/down modulo-N counter with wrap or saturate boundary handling,
// range-checked synchronous load and synchronous clear.
module updown_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;

  logic at_top, at_bot, ld_ok;
  logic do_clr, do_ld, do_up, do_dn;

  assign at_top = (count_q == MAX);
  assign at_bot = (count_q == '0);
  // Widened compare so MODULUS == 2**WIDTH never overflows
  assign ld_ok  = ({1'b0, load_val} < MODW);

  assign do_clr = clr;
  assign do_ld  = !clr && load;
  assign do_up  = !clr && !load && en && up;
  assign do_dn  = !clr && !load && en && !up;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    err_d   = 1'b0;
    unique case (1'b1)
      do_clr: count_d = '0;
      do_ld: begin
        if (ld_ok) begin
          count_d = load_val;
        end else begin
          count_d = MAX;
          err_d   = 1'b1;
        end
      end
      do_up: begin
        if (!at_top) begin
          count_d = count_q + WIDTH'(1);
        end else if (SATURATE != 0) begin
          sat_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end
      do_dn: begin
        if (!at_bot) begin
          count_d = count_q - WIDTH'(1);
        end else if (SATURATE != 0) begin
          sat_d = 1'b1;
        end else begin
          count_d = MAX;
          wrap_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;
  assign load_err = err_q;
  assign tc       = en & ((up & at_top) | (!up & at_bot));

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (2..16).
REQ-002 Parameter MODULUS, default 16, count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
REQ-003 Parameter SATURATE, default 0, boundary mode: 0 = wrap, 1 = hold at boundary.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 clr  input  1  synchronous clear to 0.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 en  input  1  count enable.
REQ-010 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 count  output  WIDTH  current count, registered.
REQ-012 tc  output  1  terminal count, combinational.
REQ-013 wrap  output  1  registered one-cycle wrap pulse.
REQ-014 sat  output  1  registered saturation-hold flag.
REQ-015 load_err  output  1  registered one-cycle pulse on out-of-range load.

Function
REQ-016 count SHALL update only on rising clk; priority clr > load > en > hold.
REQ-017 clr=1 SHALL set count=0 and clear wrap, sat, load_err next cycle, regardless of load/en.
REQ-018 load=1 (clr=0) with load_val < MODULUS SHALL set count=load_val; load_err=0.
REQ-019 load=1 with load_val >= MODULUS SHALL set count=MODULUS-1 and pulse load_err=1 for exactly one cycle.
REQ-020 en=0 (no clr/load) SHALL hold count; wrap=0, sat=0.
REQ-021 en=1, up=1, count < MODULUS-1 SHALL set count=count+1; en=1, up=0, count > 0 SHALL set count=count-1.
REQ-022 en=1, up=1, count=MODULUS-1: SATURATE=0 -> count=0, wrap=1 next cycle; SATURATE=1 -> count held, sat=1 next cycle.
REQ-023 en=1, up=0, count=0: SATURATE=0 -> count=MODULUS-1, wrap=1 next cycle; SATURATE=1 -> count held, sat=1 next cycle.
REQ-024 wrap and sat SHALL be 0 in any cycle following a non-boundary step, hold, load, or clear.
REQ-025 tc SHALL equal en & ((up & count==MODULUS-1) | (!up & count==0)), with no clr/load gating.
REQ-026 Direction change SHALL take effect on the same edge; no dead cycle.
REQ-027 Arithmetic SHALL be modulo MODULUS; count SHALL never exceed MODULUS-1 and SHALL never take an X from internal overflow when MODULUS = 2**WIDTH.
REQ-028 With WIDTH=2, MODULUS=4, SATURATE=0, behaviour SHALL match a 2-bit up/down counter with enable: en=1,up=1 steps 0->1->2->3->0; en=1,up=0 steps 0->3->2->1->0; en=0 holds.

Reset
REQ-029 rstn=0 SHALL immediately, independent of clk, force count=0, wrap=0, sat=0, load_err=0.
REQ-030 Reset asserted mid-count SHALL abort operation; first edge after rstn rises SHALL act on inputs from count=0.
REQ-031 tc SHALL follow REQ-025 during reset (count=0, so tc = en & !up).

Verification
REQ-032 Default params, rstn low 10 ns then high, en=1 up=1 for 17 cycles -> count 1..15,0,1; wrap=1 only in the cycle after count goes 15->0.
REQ-033 MODULUS=10, SATURATE=0, en=1 up=0 from 0 -> count 9,8,...; wrap pulse once; tc=1 whenever count=0.
REQ-034 MODULUS=10, SATURATE=1, count=9, en=1 up=1 for 3 cycles -> count stays 9, sat=1 for those 3 cycles; then up=0 -> count 8, sat=0.
REQ-035 MODULUS=10, load=1 load_val=12 -> count=9, load_err=1 one cycle; load=1 clr=1 load_val=5 -> count=0.
REQ-036 Default params, count=7, assert rstn=0 between edges -> count=0 immediately; release, en=1 up=1 -> count=1 on next edge.
REQ-037 WIDTH=2, MODULUS=4, en=0 up=x held 3 cycles from count=2 -> count stays 2; then en=1 up=0 -> 1,0,3.
